// File: rtl/tow_pkg.sv
// Shared types and defaults for the tug-of-war rope controller.
// The state encodings double as winner codes, so winner decodes straight from the state flops.
package tow_pkg;

  typedef enum logic [1:0] {
    ST_PLAY  = 2'b00,
    ST_WIN_L = 2'b01,
    ST_WIN_R = 2'b10
  } state_t;

  localparam logic [1:0] WINNER_NONE  = 2'b00;
  localparam logic [1:0] WINNER_LEFT  = 2'b01;
  localparam logic [1:0] WINNER_RIGHT = 2'b10;

  localparam int DEF_N_LEDS  = 7;
  localparam int DEF_SCORE_W = 4;

endpackage

// File: rtl/btn_edge_sync.sv
// Two-flop synchroniser for an asynchronous button level, plus one history flop
// that turns each press into a single-cycle rising-edge pulse.
module btn_edge_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_edge
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_btn;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_edge = r_s2 & ~r_s3;

endmodule

// File: rtl/rope_ctrl.sv
// Tug-of-war core: button edges move the lit rope LED; reaching an end latches a winner,
// lights the whole bar and bumps that player's saturating score until clear restarts play.
module rope_ctrl
  import tow_pkg::*;
#(
  parameter int N_LEDS  = DEF_N_LEDS,
  parameter int SCORE_W = DEF_SCORE_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_l,
  input  logic               btn_r,
  input  logic               clear,
  output logic [N_LEDS-1:0]  leds,
  output logic               leds_on,
  output logic [1:0]         winner,
  output logic [SCORE_W-1:0] score_l,
  output logic [SCORE_W-1:0] score_r
);

  localparam int POS_W = $clog2(N_LEDS);
  localparam logic [POS_W-1:0] CTR  = POS_W'((N_LEDS - 1) / 2);
  localparam logic [POS_W-1:0] LAST = POS_W'(N_LEDS - 1);

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (&v) ? v : v + SCORE_W'(1);
  endfunction

  logic w_edge_l;
  logic w_edge_r;

  btn_edge_sync u_sync_l (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_btn   (btn_l),
    .o_edge  (w_edge_l)
  );

  btn_edge_sync u_sync_r (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_btn   (btn_r),
    .o_edge  (w_edge_r)
  );

  state_t             r_state;
  logic [POS_W-1:0]   r_pos;
  logic [SCORE_W-1:0] r_score_l;
  logic [SCORE_W-1:0] r_score_r;

  state_t             w_state_nxt;
  logic [POS_W-1:0]   w_pos_nxt;
  logic               w_inc_l;
  logic               w_inc_r;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_PLAY;
      r_pos     <= CTR;
      r_score_l <= '0;
      r_score_r <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pos   <= w_pos_nxt;
      if (w_inc_l) r_score_l <= sat_inc(r_score_l);
      if (w_inc_r) r_score_r <= sat_inc(r_score_r);
    end
  end

  // clear outranks button edges; simultaneous edges cancel each other out
  always_comb begin
    w_state_nxt = r_state;
    w_pos_nxt   = r_pos;
    w_inc_l     = 1'b0;
    w_inc_r     = 1'b0;
    case (r_state)
      ST_PLAY: begin
        if (clear) begin
          w_pos_nxt = CTR;
        end else if (w_edge_l && !w_edge_r) begin
          w_pos_nxt = r_pos + POS_W'(1);
          if (r_pos + POS_W'(1) == LAST) begin
            w_state_nxt = ST_WIN_L;
            w_inc_l     = 1'b1;
          end
        end else if (w_edge_r && !w_edge_l) begin
          w_pos_nxt = r_pos - POS_W'(1);
          if (r_pos == POS_W'(1)) begin
            w_state_nxt = ST_WIN_R;
            w_inc_r     = 1'b1;
          end
        end
      end
      ST_WIN_L, ST_WIN_R: begin
        if (clear) begin
          w_state_nxt = ST_PLAY;
          w_pos_nxt   = CTR;
        end
      end
      default: begin
        w_state_nxt = ST_PLAY;
        w_pos_nxt   = CTR;
      end
    endcase
  end

  always_comb begin
    leds    = (r_state == ST_PLAY) ? (N_LEDS'(1) << r_pos) : {N_LEDS{1'b1}};
    leds_on = (r_state != ST_PLAY);
    case (r_state)
      ST_WIN_L: winner = WINNER_LEFT;
      ST_WIN_R: winner = WINNER_RIGHT;
      default:  winner = WINNER_NONE;
    endcase
  end

  assign score_l = r_score_l;
  assign score_r = r_score_r;

endmodule

// File: tb/tb_rope_ctrl.sv
// Directed bench for rope_ctrl: reset, press latency, wins, clear, ties, saturation and async reset.
module tb_rope_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_l;
  logic       btn_r;
  logic       clear;
  logic [6:0] leds;
  logic       leds_on;
  logic [1:0] winner;
  logic [3:0] score_l;
  logic [3:0] score_r;

  int errs   = 0;
  int checks = 0;

  rope_ctrl #(.N_LEDS(7), .SCORE_W(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_l   (btn_l),
    .btn_r   (btn_r),
    .clear   (clear),
    .leds    (leds),
    .leds_on (leds_on),
    .winner  (winner),
    .score_l (score_l),
    .score_r (score_r)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // 3 cycles high covers the sync latency, 3 low re-arms the edge detector
  task automatic press(input bit left, input bit right);
    btn_l = left;
    btn_r = right;
    tick(3);
    btn_l = 1'b0;
    btn_r = 1'b0;
    tick(3);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; btn_l = 1'b0; btn_r = 1'b0; clear = 1'b0;
    tick(2);
    checks++;
    if (leds !== 7'b0001000 || leds_on !== 1'b0 || winner !== 2'b00 ||
        score_l !== 4'd0 || score_r !== 4'd0) begin
      errs++;
      $display("FAIL reset_hold: leds=%b on=%b win=%b sl=%0d sr=%0d want 0001000 0 00 0 0",
               leds, leds_on, winner, score_l, score_r);
    end
    rst = 1'b1;
    tick(10);
    checks++;
    if (leds !== 7'b0001000 || leds_on !== 1'b0 || winner !== 2'b00 ||
        score_l !== 4'd0 || score_r !== 4'd0) begin
      errs++;
      $display("FAIL reset_idle: leds=%b on=%b win=%b sl=%0d sr=%0d want 0001000 0 00 0 0",
               leds, leds_on, winner, score_l, score_r);
    end
  endtask

  task automatic test_single_press();
    btn_l = 1'b1;
    tick(2);
    checks++;
    if (leds !== 7'b0001000) begin
      errs++;
      $display("FAIL press_early: leds=%b want 0001000", leds);
    end
    tick(1);
    checks++;
    if (leds !== 7'b0010000) begin
      errs++;
      $display("FAIL press_3rd_edge: leds=%b want 0010000", leds);
    end
    tick(17);
    checks++;
    if (leds !== 7'b0010000) begin
      errs++;
      $display("FAIL press_held: leds=%b want 0010000", leds);
    end
    btn_l = 1'b0;
    tick(5);
    checks++;
    if (leds !== 7'b0010000) begin
      errs++;
      $display("FAIL press_release: leds=%b want 0010000", leds);
    end
  endtask

  task automatic test_left_win();
    pulse_clear();
    tick(1);
    checks++;
    if (leds !== 7'b0001000) begin
      errs++;
      $display("FAIL play_clear: leds=%b want 0001000", leds);
    end
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    checks++;
    if (leds !== 7'b0100000 || leds_on !== 1'b0) begin
      errs++;
      $display("FAIL left_two: leds=%b on=%b want 0100000 0", leds, leds_on);
    end
    press(1'b1, 1'b0);
    checks++;
    if (leds !== 7'b1111111 || leds_on !== 1'b1 || winner !== 2'b01 || score_l !== 4'd1) begin
      errs++;
      $display("FAIL left_win: leds=%b on=%b win=%b sl=%0d want 1111111 1 01 1",
               leds, leds_on, winner, score_l);
    end
    press(1'b0, 1'b1);
    press(1'b1, 1'b0);
    checks++;
    if (leds !== 7'b1111111 || winner !== 2'b01 || score_l !== 4'd1 || score_r !== 4'd0) begin
      errs++;
      $display("FAIL win_ignore: leds=%b win=%b sl=%0d sr=%0d want 1111111 01 1 0",
               leds, winner, score_l, score_r);
    end
  endtask

  task automatic test_clear();
    pulse_clear();
    checks++;
    if (leds !== 7'b0001000 || leds_on !== 1'b0 || winner !== 2'b00 || score_l !== 4'd1) begin
      errs++;
      $display("FAIL win_clear: leds=%b on=%b win=%b sl=%0d want 0001000 0 00 1",
               leds, leds_on, winner, score_l);
    end
  endtask

  task automatic test_tie_priority();
    press(1'b1, 1'b1);
    checks++;
    if (leds !== 7'b0001000) begin
      errs++;
      $display("FAIL tie: leds=%b want 0001000", leds);
    end
    btn_l = 1'b1;
    clear = 1'b1;
    tick(4);
    clear = 1'b0;
    tick(4);
    btn_l = 1'b0;
    tick(3);
    checks++;
    if (leds !== 7'b0001000) begin
      errs++;
      $display("FAIL clear_priority: leds=%b want 0001000", leds);
    end
    press(1'b0, 1'b1);
    checks++;
    if (leds !== 7'b0000100) begin
      errs++;
      $display("FAIL right_move: leds=%b want 0000100", leds);
    end
    pulse_clear();
  endtask

  task automatic test_saturation();
    for (int w = 1; w <= 16; w++) begin
      press(1'b0, 1'b1);
      press(1'b0, 1'b1);
      press(1'b0, 1'b1);
      if (w == 1 || w == 15 || w == 16) begin
        checks++;
        if (leds !== 7'b1111111 || winner !== 2'b10 || score_r !== 4'((w > 15) ? 15 : w)) begin
          errs++;
          $display("FAIL right_win_%0d: leds=%b win=%b sr=%0d want 1111111 10 %0d",
                   w, leds, winner, score_r, (w > 15) ? 15 : w);
        end
      end
      pulse_clear();
    end
    checks++;
    if (score_r !== 4'd15 || score_l !== 4'd1 || leds !== 7'b0001000) begin
      errs++;
      $display("FAIL sat_hold: sr=%0d sl=%0d leds=%b want 15 1 0001000", score_r, score_l, leds);
    end
  endtask

  task automatic test_async_reset();
    press(1'b1, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (leds !== 7'b0001000 || leds_on !== 1'b0 || winner !== 2'b00 ||
        score_l !== 4'd0 || score_r !== 4'd0) begin
      errs++;
      $display("FAIL async_reset: leds=%b on=%b win=%b sl=%0d sr=%0d want 0001000 0 00 0 0",
               leds, leds_on, winner, score_l, score_r);
    end
    tick(2);
    rst = 1'b1;
    tick(2);
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_left_win();
    test_clear();
    test_tie_priority();
    test_saturation();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
